// File: rtl/snn_pkg.sv
// Shared constants and state type for the SNN layer sequencer.
// Default geometry: 784 binary pixels feeding 32 neurons.
package snn_pkg;

  localparam int NUM_INPUTS_DEF  = 784;
  localparam int NUM_NEURONS_DEF = 32;

  localparam int IN_AW_DEF = $clog2(NUM_INPUTS_DEF);
  localparam int N_W_DEF   = $clog2(NUM_NEURONS_DEF);
  localparam int WT_AW_DEF =
    $clog2(NUM_INPUTS_DEF * NUM_NEURONS_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SWEEP,
    S_DRAIN,
    S_NDONE,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/snn_mod_counter.sv
// Modulo-N up-counter with clear, increment and terminal-count flag.
// Used for the pixel sweep index and the neuron index.
module snn_mod_counter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

  // Count up, wrapping to zero after the terminal value.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_tc ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/snn_layer_sequencer.sv
// Sweeps all pixels once per neuron, driving weight ROM and accumulator.
// Optional macro SNN_SEQ_STALL_EN adds a 'stall' input that freezes it.
module snn_layer_sequencer
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS  = NUM_INPUTS_DEF,
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int IN_AW       = IN_AW_DEF,
  parameter int N_W         = N_W_DEF,
  parameter int WT_AW       = WT_AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             image_ready,
  input  logic             in_bit,
`ifdef SNN_SEQ_STALL_EN
  input  logic             stall,
`endif
  output logic             busy,
  output logic [IN_AW-1:0] in_addr,
  output logic [WT_AW-1:0] wt_addr,
  output logic             acc_clr,
  output logic             acc_en,
  output logic [N_W-1:0]   neuron_idx,
  output logic             neuron_done,
  output logic             done,
  output logic             consume
);

  seq_state_t       r_state;
  logic             r_v_d1;
  logic             w_run;
  logic             w_accept;
  logic [IN_AW-1:0] w_pix;
  logic             w_pix_tc;
  logic [N_W-1:0]   w_nidx;
  logic             w_nidx_tc;
  logic             w_pix_clr;
  logic             w_pix_inc;
  logic             w_n_clr;
  logic             w_n_inc;

`ifdef SNN_SEQ_STALL_EN
  assign w_run = ~stall;
`else
  assign w_run = 1'b1;
`endif

  assign w_accept  = (r_state == S_IDLE)
                   & start & image_ready;
  assign w_pix_clr = w_run & (r_state == S_CLEAR);
  assign w_pix_inc = w_run & (r_state == S_SWEEP);
  assign w_n_clr   = w_run & w_accept;
  assign w_n_inc   = w_run & (r_state == S_NDONE)
                   & ~w_nidx_tc;

  snn_mod_counter #(
    .N (NUM_INPUTS),
    .W (IN_AW)
  ) u_pix (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_pix_clr),
    .i_inc (w_pix_inc),
    .o_cnt (w_pix),
    .o_tc  (w_pix_tc)
  );

  snn_mod_counter #(
    .N (NUM_NEURONS),
    .W (N_W)
  ) u_nidx (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_n_clr),
    .i_inc (w_n_inc),
    .o_cnt (w_nidx),
    .o_tc  (w_nidx_tc)
  );

  // Layer FSM: clear, sweep, drain and report for each neuron.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (w_run) begin
      unique case (r_state)
        S_IDLE:  if (w_accept) r_state <= S_CLEAR;
        S_CLEAR: r_state <= S_SWEEP;
        S_SWEEP: if (w_pix_tc) r_state <= S_DRAIN;
        S_DRAIN: r_state <= S_NDONE;
        S_NDONE: r_state <= w_nidx_tc ? S_DONE
                                      : S_CLEAR;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sweep-valid delayed to line up with the buffered pixel bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_d1 <= 1'b0;
    end else if (w_run) begin
      r_v_d1 <= (r_state == S_SWEEP);
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign in_addr     = w_pix;
  assign neuron_idx  = w_nidx;
  assign wt_addr     = WT_AW'(w_nidx) * WT_AW'(NUM_INPUTS)
                     + WT_AW'(w_pix);
  assign acc_clr     = w_run & (r_state == S_CLEAR);
  assign acc_en      = w_run & r_v_d1 & in_bit;
  assign neuron_done = w_run & (r_state == S_NDONE);
  assign done        = w_run & (r_state == S_DONE);
  assign consume     = done;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Directed bench for snn_layer_sequencer with a 2-neuron layer.
// Buffer model returns pixel parity one cycle after the address.
module tb_snn_layer_sequencer;

  localparam int NN = 2;
`ifdef SNN_SEQ_STALL_EN
  localparam int STALL_CYC = 5;
`else
  localparam int STALL_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        image_ready = 1'b0;
  logic        in_bit = 1'b0;
  logic        stall = 1'b0;
  logic        busy;
  logic [9:0]  in_addr;
  logic [14:0] wt_addr;
  logic        acc_clr;
  logic        acc_en;
  logic [4:0]  neuron_idx;
  logic        neuron_done;
  logic        done;
  logic        consume;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!stall) in_bit <= in_addr[0];

  snn_layer_sequencer #(
    .NUM_NEURONS (NN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .image_ready (image_ready),
    .in_bit      (in_bit),
`ifdef SNN_SEQ_STALL_EN
    .stall       (stall),
`endif
    .busy        (busy),
    .in_addr     (in_addr),
    .wt_addr     (wt_addr),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .neuron_idx  (neuron_idx),
    .neuron_done (neuron_done),
    .done        (done),
    .consume     (consume)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  initial begin
    int cyc, nclr, nd_n, done_cyc, max_addr;
    int walk_bad, steps, prev_addr, wt5, busy_drop;
    int stall_left, k, ndn;
    int acc_cnt [2];
    int nd_cyc [2];
    bit got5, stall_used;

    tick;
    tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_addr", 32'(in_addr), 0);
    chk("rst_wt_addr", 32'(wt_addr), 0);
    chk("rst_nidx", 32'(neuron_idx), 0);
    chk("rst_pulses",
        32'({acc_clr, acc_en, neuron_done, done, consume}), 0);
    rst = 1'b0;

    start = 1'b1;
    image_ready = 1'b0;
    tick;
    start = 1'b0;
    chk("drop_busy", 32'(busy), 0);
    repeat (10) tick;
    image_ready = 1'b1;
    repeat (3) tick;
    chk("late_rdy_busy", 32'(busy), 0);
    chk("late_rdy_clr", 32'(acc_clr), 0);

    cyc = 0; nclr = 0; nd_n = 0; done_cyc = -1;
    max_addr = 0; walk_bad = 0; steps = 0;
    prev_addr = 0; wt5 = -1; busy_drop = 0;
    stall_left = 0; got5 = 0; stall_used = 0;
    acc_cnt = '{0, 0};
    nd_cyc = '{-1, -1};
    start = 1'b1;
    while (1) begin
      tick;
      cyc++;
      start = (cyc == 300);
      if (stall) begin
        if (stall_left == 0) stall = 1'b0;
      end else if (STALL_CYC > 0 && !stall_used &&
                   busy && neuron_idx == 0 &&
                   in_addr == 100) begin
        stall = 1'b1;
        stall_left = STALL_CYC;
        stall_used = 1;
      end
      #1;
      if (cyc == 1) begin
        chk("first_clr", 32'(acc_clr), 1);
        chk("first_busy", 32'(busy), 1);
      end
      if (!busy) busy_drop++;
      if (acc_clr) nclr++;
      if (acc_en && neuron_idx < NN)
        acc_cnt[neuron_idx]++;
      if (neuron_done) begin
        if (nd_n < 2) nd_cyc[nd_n] = cyc;
        nd_n++;
      end
      if (32'(in_addr) > max_addr) max_addr = 32'(in_addr);
      if (32'(in_addr) != prev_addr) begin
        if (32'(in_addr) == prev_addr + 1) steps++;
        else if (in_addr != 0) walk_bad++;
        prev_addr = 32'(in_addr);
      end
      if (!got5 && neuron_idx == 1 && in_addr == 5) begin
        wt5 = 32'(wt_addr);
        got5 = 1;
      end
      if (stall) begin
        chk("stall_addr", 32'(in_addr), 100);
        chk("stall_acc_en", 32'(acc_en), 0);
        stall_left--;
      end
      if (done) begin
        done_cyc = cyc;
        chk("consume_w_done", 32'(consume), 1);
        chk("busy_at_done", 32'(busy), 1);
        break;
      end
      if (cyc >= 3000) break;
    end
    start = 1'b0;
    chk("done_cycle", done_cyc, 1575 + STALL_CYC);
    chk("ndone0_cycle", nd_cyc[0], 787 + STALL_CYC);
    chk("ndone1_cycle", nd_cyc[1], 1574 + STALL_CYC);
    chk("ndone_count", nd_n, 2);
    chk("clr_count", nclr, 2);
    chk("acc_n0", acc_cnt[0], 392);
    chk("acc_n1", acc_cnt[1], 392);
    chk("max_in_addr", max_addr, 783);
    chk("walk_bad", walk_bad, 0);
    chk("walk_steps", steps, 1566);
    chk("wt_n1_p5", wt5, 789);
    chk("busy_drop", busy_drop, 0);
    tick;
    chk("post_busy", 32'(busy), 0);
    chk("post_done", 32'(done), 0);
    chk("post_consume", 32'(consume), 0);

    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0;
    while (in_addr != 400 && k < 1000) begin
      tick;
      k++;
    end
    chk("rst_reach_400", 32'(in_addr), 400);
    rst = 1'b1;
    tick;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", 32'(in_addr), 0);
    chk("mid_rst_wt", 32'(wt_addr), 0);
    chk("mid_rst_pulses",
        32'({acc_clr, acc_en, neuron_done, done, consume}), 0);
    rst = 1'b0;
    ndn = 0;
    repeat (1700) begin
      tick;
      if (done || consume || busy) ndn++;
    end
    chk("aborted_no_done", ndn, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_layer_sequencer.md
# snn_layer_sequencer

Controller that sequences one fully connected layer of the SNN over the 784-pixel binary input image held in the input loader. After an image is loaded and a start pulse arrives, it sweeps input addresses 0..783 once per neuron and drives the weight-ROM address and accumulator controls. It pulses per-neuron and whole-layer completion, then releases the image buffer back to the loader. It sits between the input loader, the weight ROM and the neuron accumulator datapath.

## Interface
- NUM_INPUTS, 784, pixels per image; one input bit per pixel.
- NUM_NEURONS, 32, neurons evaluated per layer pass.
- IN_AW, 10, width of `in_addr`; must satisfy 2^IN_AW ≥ NUM_INPUTS.
- N_W, 5, width of `neuron_idx`; must satisfy 2^N_W ≥ NUM_NEURONS.
- WT_AW, 15, width of `wt_addr`; must satisfy 2^WT_AW ≥ NUM_NEURONS*NUM_INPUTS.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run the layer.
- image_ready  in  1  level input from the loader; high while a complete image is buffered.
- in_bit  in  1  buffered pixel bit; valid the cycle after `in_addr` is presented.
- busy  out  1  high from start acceptance through the DONE cycle inclusive.
- in_addr  out  IN_AW  pixel address to the input buffer.
- wt_addr  out  WT_AW  weight address, equal to neuron_idx*NUM_INPUTS + in_addr (synchronous ROM, 1-cycle latency).
- acc_clr  out  1  clears the neuron accumulator.
- acc_en  out  1  adds the current weight; equals registered sweep-valid AND in_bit.
- neuron_idx  out  N_W  index of the neuron being evaluated.
- neuron_done  out  1  1-cycle pulse when the accumulator holds the final sum for neuron_idx.
- done  out  1  1-cycle pulse at layer completion.
- consume  out  1  1-cycle pulse, coincident with `done`, that tells the loader the image is used.

## Operation
- States: IDLE, CLEAR, SWEEP, DRAIN, NDONE, DONE.
- IDLE:
  - Start is accepted only when start=1 and image_ready=1; the FSM then goes to CLEAR and sets neuron_idx=0.
  - start with image_ready=0 is dropped, not latched.
- CLEAR: acc_clr=1 for one cycle, pix=0, then SWEEP.
- SWEEP:
  - in_addr=pix each cycle; pix increments.
  - At pix==NUM_INPUTS-1 the FSM goes to DRAIN. in_addr never exceeds NUM_INPUTS-1.
- Valid pipeline: register v_d1 = (state==SWEEP). acc_en = v_d1 & in_bit, so the last pixel accumulates during DRAIN.
- DRAIN: one cycle with no new address, then NDONE.
- NDONE:
  - neuron_done=1.
  - If neuron_idx==NUM_NEURONS-1, go to DONE. Otherwise increment neuron_idx and go to CLEAR.
  - neuron_idx saturates; it never wraps.
- DONE: done=1 and consume=1, then IDLE.
- start while busy is ignored. image_ready dropping mid-run has no effect.
- wt_addr arithmetic: unsigned, computed as neuron_idx*NUM_INPUTS + pix with no truncation within WT_AW.

## Timing
- Reset values: busy, acc_clr, acc_en, neuron_done, done and consume are 0; in_addr, wt_addr and neuron_idx are 0; state is IDLE; v_d1 is 0.
- All outputs are registered or decoded from registered state. No combinational path from start to any output.
- Per-neuron cost: 1 CLEAR + NUM_INPUTS SWEEP + 1 DRAIN + 1 NDONE = 787 cycles.
- Layer cost: 787*NUM_NEURONS + 1 cycles, counted from the cycle after start acceptance to `done` inclusive.
- rst mid-run: IDLE on the next edge with all outputs at reset values. No done or consume is issued for the aborted run.

## Configuration
- Macro: SNN_SEQ_STALL_EN.
- When defined:
  - Adds input `stall` (1 bit).
  - While stall=1, state, pix, neuron_idx and v_d1 all hold.
  - acc_clr, acc_en, neuron_done, done and consume are forced to 0; held pulses fire after stall drops.
  - in_addr holds, so the buffer output stays stable.
  - Each stall cycle adds exactly one cycle to the latency.
- When undefined: no `stall` port; behaviour as above.

## Structure
- Shared package snn_pkg:
  - NUM_INPUTS and NUM_NEURONS defaults.
  - Derived widths via $clog2.
  - seq_state_t enum for the six states.
- One sub-module, snn_mod_counter: parameterised modulo-N up-counter with clr, inc and a terminal-count flag. It is instantiated for pix and for neuron_idx.

## Test plan
- Reset then start with image_ready=1, NUM_NEURONS=2 → first acc_clr 1 cycle after acceptance; in_addr walks 0..783; neuron_done at cycles 787 and 1574; done/consume at 1575; busy low after that.
- Buffer model with in_bit = pixel parity (1 on odd addresses) → acc_en pulses count exactly 392 per neuron; wt_addr for neuron 1, pixel 5 equals 789.
- start with image_ready=0, then image_ready raised 10 cycles later with no new start → FSM stays IDLE, busy=0.
- start pulsed again at cycle 300 of a run → ignored; total latency unchanged at 1575.
- rst asserted during SWEEP at in_addr=400 → next cycle all outputs 0 and state IDLE; done never pulses.
- With SNN_SEQ_STALL_EN: stall high for 5 cycles at in_addr=100 → in_addr holds at 100, acc_en=0 during the stall, done arrives at 1580, acc_en count unchanged.
